// File: rtl/fexp2_bf16_if.sv
// Operand/result bundle for the bfloat16 2^x unit: split-field operand in,
// split-field result out, valid/ready handshake on the operand side.
interface fexp2_bf16_if #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7
);
  logic                   sign;
  logic [EXP_WIDTH-1:0]   exponent;
  logic [FRACT_WIDTH-1:0] fractional;
  logic                   valid_i;
  logic                   ready_o;
  logic                   s_res_o;
  logic [EXP_WIDTH-1:0]   e_res_o;
  logic [FRACT_WIDTH-1:0] f_res_o;
  logic                   valid_o;

  modport master (
    output sign, exponent, fractional, valid_i,
    input  ready_o, s_res_o, e_res_o, f_res_o, valid_o
  );
  modport slave (
    input  sign, exponent, fractional, valid_i,
    output ready_o, s_res_o, e_res_o, f_res_o, valid_o
  );
endinterface

// File: rtl/fexp2_bf16.sv
// Sequential bfloat16 2^x: x -> n + f (Q8.16), 2^f by one shift-multiply per
// fraction bit against a 2^(2^-i) ROM, then RNE to bf16. Fixed 18-cycle latency.
module fexp2_bf16 #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7,
  parameter int N_ITER      = 16
) (
  input  logic         clk,
  input  logic         rst,
  fexp2_bf16_if.slave  io
);
  typedef enum logic [1:0] {IDLE, CONV, ITER, NORM} state_t;

  localparam logic [21:0] ONE = 22'd1048576;

  state_t                 state_q, state_d;
  logic                   sign_q;
  logic [EXP_WIDTH-1:0]   exp_q;
  logic [FRACT_WIDTH-1:0] frac_q;
  logic signed [8:0]      n_q;
  logic [15:0]            fr_q;
  logic [3:0]             cnt_q;
  logic [21:0]            p_q;
  logic                   force_q;
  logic [14:0]            force_val_q;
  logic [EXP_WIDTH-1:0]   e_res_q;
  logic [FRACT_WIDTH-1:0] f_res_q;
  logic                   valid_q;

  // c_i = round(2^(2^-i) * 2^20), indexed by counter = i-1
  function automatic logic [21:0] rom_c(input logic [3:0] k);
    case (k)
      4'd0:    rom_c = 22'd1482910;
      4'd1:    rom_c = 22'd1246974;
      4'd2:    rom_c = 22'd1143480;
      4'd3:    rom_c = 22'd1095000;
      4'd4:    rom_c = 22'd1071537;
      4'd5:    rom_c = 22'd1059994;
      4'd6:    rom_c = 22'd1054270;
      4'd7:    rom_c = 22'd1051419;
      4'd8:    rom_c = 22'd1049997;
      4'd9:    rom_c = 22'd1049286;
      4'd10:   rom_c = 22'd1048931;
      4'd11:   rom_c = 22'd1048753;
      4'd12:   rom_c = 22'd1048665;
      4'd13:   rom_c = 22'd1048620;
      4'd14:   rom_c = 22'd1048598;
      default: rom_c = 22'd1048587;
    endcase
  endfunction

  // Conversion of the registered operand, consumed in CONV
  logic [7:0]  mant8;
  logic [23:0] mag;
  logic [24:0] t;
  logic        spec;
  logic [14:0] spec_val;

  always_comb begin
    mant8 = {1'b1, frac_q};
    if (exp_q >= 8'd118) mag = {16'b0, mant8} << (exp_q - 8'd118);
    else                 mag = {16'b0, mant8} >> (8'd118 - exp_q);
    t = sign_q ? (25'd0 - {1'b0, mag}) : {1'b0, mag};

    spec     = 1'b1;
    spec_val = 15'h0000;
    if (exp_q == 8'hFF) begin
      if (frac_q != '0) spec_val = 15'h7FC0;
      else              spec_val = sign_q ? 15'h0000 : 15'h7F80;
    end else if (exp_q == 8'h00) begin
      spec_val = 15'h3F80;
    end else if (exp_q >= 8'd134) begin
      spec_val = sign_q ? 15'h0000 : 15'h7F80;
    end else begin
      spec = 1'b0;
    end
  end

  logic [43:0] prod;
  logic [21:0] p_mul;
  assign prod  = p_q * rom_c(cnt_q);
  assign p_mul = 22'(prod >> 20);

  // Round-to-nearest-even on P, carry bumps the exponent
  logic [6:0]         mant;
  logic               rnd;
  logic [7:0]         mant_r;
  logic signed [10:0] e_b;
  logic [14:0]        norm_val;

  always_comb begin
    mant   = p_q[19:13];
    rnd    = p_q[12] & ((|p_q[11:0]) | mant[0]);
    mant_r = {1'b0, mant} + {7'b0, rnd};
    e_b    = {{2{n_q[8]}}, n_q} + {10'b0, mant_r[7]} + 11'sd127;
    if (force_q)             norm_val = force_val_q;
    else if (e_b >= 11'sd255) norm_val = 15'h7F80;
    else if (e_b <= 11'sd0)   norm_val = 15'h0000;
    else                     norm_val = {e_b[7:0], mant_r[6:0]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.valid_i) state_d = CONV;
      CONV:    state_d = ITER;
      ITER:    if (cnt_q == 4'(N_ITER - 1)) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      n_q         <= '0;
      fr_q        <= '0;
      cnt_q       <= '0;
      p_q         <= ONE;
      force_q     <= 1'b0;
      force_val_q <= '0;
      e_res_q     <= '0;
      f_res_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (io.valid_i) begin
          sign_q <= io.sign;
          exp_q  <= io.exponent;
          frac_q <= io.fractional;
        end
        CONV: begin
          n_q         <= t[24:16];
          fr_q        <= t[15:0];
          cnt_q       <= '0;
          p_q         <= ONE;
          force_q     <= spec;
          force_val_q <= spec_val;
        end
        ITER: begin
          if (fr_q[15]) p_q <= p_mul;
          fr_q  <= fr_q << 1;
          cnt_q <= cnt_q + 4'd1;
        end
        NORM: begin
          e_res_q <= norm_val[14:7];
          f_res_q <= norm_val[6:0];
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io.ready_o = (state_q == IDLE);
  assign io.s_res_o = 1'b0;
  assign io.e_res_o = e_res_q;
  assign io.f_res_o = f_res_q;
  assign io.valid_o = valid_q;
endmodule

// File: tb/tb_fexp2_bf16.sv
// Directed bench for fexp2_bf16: hand-computed bf16 results, 18-cycle latency,
// back-to-back issue, ignored valid_i while busy, and mid-operation reset.
module tb_fexp2_bf16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  fexp2_bf16_if #(.EXP_WIDTH(8), .FRACT_WIDTH(7)) bus();

  fexp2_bf16 #(.EXP_WIDTH(8), .FRACT_WIDTH(7), .N_ITER(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] res_now();
    return {bus.s_res_o, bus.e_res_o, bus.f_res_o};
  endfunction

  task automatic drive(input logic [15:0] x, input logic v);
    bus.sign       = x[15];
    bus.exponent   = x[14:7];
    bus.fractional = x[6:0];
    bus.valid_i    = v;
  endtask

  // Present x for one edge; caller is positioned just after an edge
  task automatic accept(input logic [15:0] x, input string nm);
    drive(x, 1'b1);
    checks++;
    if (bus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_o before issue: got %b want 1", nm, bus.ready_o);
    end
    @(posedge clk); #1;
    drive(x, 1'b0);
  endtask

  task automatic wait_result(output logic [15:0] r, output int lat, output int rdy_hi);
    lat = -1; r = 16'h0; rdy_hi = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid_o === 1'b1) begin
        lat = k; r = res_now();
        break;
      end
      if (bus.ready_o === 1'b1) rdy_hi++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] r; int lat, rh;
    rst = 1'b1;
    drive(16'h4040, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b valid=%b want ready=1 valid=0", bus.ready_o, bus.valid_o);
    end
    checks++;
    if (res_now() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_res: got %h want 0000", res_now());
    end
    rst = 1'b0;
    drive(16'h0000, 1'b0);
    wait_result(r, lat, rh);
    checks++;
    if (lat !== -1) begin
      errors++;
      $display("FAIL reset_valid_i_ignored: valid_o at %0d want none", lat);
    end
  endtask

  task automatic test_basic();
    logic [15:0] r; int lat, rh;
    accept(16'h4040, "basic");
    wait_result(r, lat, rh);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL basic_latency: got %0d want 18", lat); end
    checks++;
    if (r !== 16'h4100) begin errors++; $display("FAIL basic_result: got %h want 4100", r); end
    checks++;
    if (rh !== 0) begin errors++; $display("FAIL basic_ready_busy: ready high %0d cycles want 0", rh); end
    @(posedge clk); #1;
    checks++;
    if (bus.valid_o !== 1'b0 || res_now() !== 16'h4100) begin
      errors++;
      $display("FAIL basic_pulse_hold: valid=%b res=%h want valid=0 res=4100", bus.valid_o, res_now());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r; int lat, rh;
    accept(16'h3F00, "b2b_first");
    wait_result(r, lat, rh);
    checks++;
    if (lat !== 18 || r !== 16'h3FB5) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d want 3fb5 lat 18", r, lat);
    end
    accept(16'hBF00, "b2b_second");
    wait_result(r, lat, rh);
    checks++;
    if (lat !== 18 || r !== 16'h3F35) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d want 3f35 lat 18", r, lat);
    end
  endtask

  task automatic test_values();
    logic [15:0] vin [8] = '{16'hBF80, 16'h0000, 16'h8001, 16'h4300,
                             16'hC300, 16'h7FC1, 16'hFF80, 16'h7F80};
    logic [15:0] vexp [8] = '{16'h3F00, 16'h3F80, 16'h3F80, 16'h7F80,
                              16'h0000, 16'h7FC0, 16'h0000, 16'h7F80};
    logic [15:0] r; int lat, rh;
    for (int i = 0; i < 8; i++) begin
      accept(vin[i], "values");
      wait_result(r, lat, rh);
      checks++;
      if (lat !== 18 || r !== vexp[i]) begin
        errors++;
        $display("FAIL values x=%h: got %h lat %0d want %h lat 18", vin[i], r, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [15:0] r; int lat, pulses;
    lat = -1; r = 16'h0; pulses = 0;
    accept(16'h4040, "ignore");
    for (int k = 1; k <= 40; k++) begin
      drive(16'h3F00, (k >= 4 && k < 9));
      @(posedge clk); #1;
      if (bus.valid_o === 1'b1) begin
        pulses++;
        if (lat == -1) begin lat = k; r = res_now(); end
      end
    end
    drive(16'h0000, 1'b0);
    checks++;
    if (pulses !== 1 || lat !== 18 || r !== 16'h4100) begin
      errors++;
      $display("FAIL ignore_busy: pulses %0d lat %0d res %h want 1, 18, 4100", pulses, lat, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; int lat, rh;
    accept(16'h3F00, "rst_mid");
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || res_now() !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_state: ready=%b valid=%b res=%h want 1 0 0000",
               bus.ready_o, bus.valid_o, res_now());
    end
    wait_result(r, lat, rh);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL rst_mid_no_valid: valid_o at %0d want none", lat); end
    accept(16'h3F00, "rst_mid_after");
    wait_result(r, lat, rh);
    checks++;
    if (lat !== 18 || r !== 16'h3FB5) begin
      errors++;
      $display("FAIL rst_mid_after: got %h lat %0d want 3fb5 lat 18", r, lat);
    end
  endtask

  initial begin
    drive(16'h0000, 1'b0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_values();
    test_ignore_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
